// File: rtl/irq_pkg.sv
// Shared sizing and defaults for the interrupt pending latch.
package irq_pkg;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 3;
    localparam logic [N_LINES-1:0] EDGE_MODE_DEFAULT = 8'hFF;
endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one async line with rising-edge detect.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);
    logic [SYNC_STAGES-1:0] s;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            prev <= 1'b0;
        end else begin
            s    <= {s[SYNC_STAGES-2:0], async_in};
            prev <= s[SYNC_STAGES-1];
        end
    end

    assign sync_out = s[SYNC_STAGES-1];
    assign rise     = s[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/irq_pending_latch.sv
// Latches async interrupt requests into pending bits and presents them to an 8x3 priority encoder.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [N_LINES-1:0] EDGE_MODE   = EDGE_MODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] req,
    input  logic [N_LINES-1:0] mask,
    input  logic               ack,
    input  logic [IDX_W-1:0]   ack_idx,
    input  logic               ovr_clr,
    output logic [N_LINES-1:0] X,
    output logic               E,
    output logic               irq,
    output logic [N_LINES-1:0] ovr,
    output logic               ack_err
);
    logic [N_LINES-1:0] synced;
    logic [N_LINES-1:0] rise;
    logic [N_LINES-1:0] pending;
    logic [N_LINES-1:0] pending_nxt;
    logic [N_LINES-1:0] clr;
    logic [N_LINES-1:0] ovr_set;
    logic               ack_err_nxt;

    for (genvar i = 0; i < int'(N_LINES); i++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (req[i]),
            .sync_out (synced[i]),
            .rise     (rise[i])
        );
    end

    // A set coinciding with a clear keeps the bit so the new event is not lost.
    always_comb begin
        clr         = '0;
        pending_nxt = '0;
        if (ack) begin
            clr[ack_idx] = 1'b1;
        end
        for (int i = 0; i < int'(N_LINES); i++) begin
            if (EDGE_MODE[i]) begin
                pending_nxt[i] = rise[i] | (pending[i] & ~clr[i]);
            end else begin
                pending_nxt[i] = synced[i];
            end
        end
        ovr_set     = rise & pending & ~clr & EDGE_MODE;
        ack_err_nxt = ack & EDGE_MODE[ack_idx] & ~pending[ack_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            ovr     <= '0;
            ack_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            ovr     <= ovr_set | (ovr_clr ? '0 : ovr);
            ack_err <= ack_err_nxt;
        end
    end

    assign X   = pending & ~mask;
    assign E   = ~|X;
    assign irq = ~E;
endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: all-edge instance plus one with line 7 in level mode.
module tb_irq_pending_latch;
    localparam logic [7:0] EM_A = 8'hFF;
    localparam logic [7:0] EM_B = 8'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic       ovr_clr = 1'b0;

    logic [7:0] x_a, x_b, ovr_a, ovr_b;
    logic       e_a, e_b, irq_a, irq_b, aerr_a, aerr_b;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(EM_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .mask(mask), .ack(ack), .ack_idx(ack_idx),
        .ovr_clr(ovr_clr), .X(x_a), .E(e_a), .irq(irq_a), .ovr(ovr_a), .ack_err(aerr_a)
    );

    irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(EM_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .mask(mask), .ack(ack), .ack_idx(ack_idx),
        .ovr_clr(ovr_clr), .X(x_b), .E(e_b), .irq(irq_b), .ovr(ovr_b), .ack_err(aerr_b)
    );

    // Stand-in for P_E_8X3: highest set bit wins, 0 when nothing is set.
    function automatic logic [2:0] enc(input logic [7:0] x);
        logic [2:0] y;
        y = 3'd0;
        for (int i = 0; i < 8; i++) if (x[i]) y = 3'(i);
        return y;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: request history since reset; a line's synced value is the sample two edges back.
    logic [7:0] hist0[2], hist1[2], hist2[2];
    logic [7:0] m_pend[2], m_ovr[2];
    logic       m_aerr[2];

    task automatic model_step(input int k, input logic [7:0] rq, input logic [7:0] em);
        logic [7:0] synced, rise, old;
        if (rst) begin
            hist0[k] = 8'h00; hist1[k] = 8'h00; hist2[k] = 8'h00;
            m_pend[k] = 8'h00; m_ovr[k] = 8'h00; m_aerr[k] = 1'b0;
            return;
        end
        synced = hist1[k];
        rise   = hist1[k] & ~hist2[k];
        old    = m_pend[k];
        m_aerr[k] = ack && em[ack_idx] && !old[ack_idx];
        if (ovr_clr) m_ovr[k] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (em[j]) begin
                logic c;
                c = ack && (int'(ack_idx) == j);
                if (rise[j] && old[j] && !c) m_ovr[k][j] = 1'b1;
                m_pend[k][j] = rise[j] || (old[j] && !c);
            end else begin
                m_pend[k][j] = synced[j];
            end
        end
        hist2[k] = hist1[k];
        hist1[k] = hist0[k];
        hist0[k] = rq;
    endtask

    always @(posedge clk) begin
        model_step(0, req_a, EM_A);
        model_step(1, req_b, EM_B);
        started = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            logic [7:0] xa, xb;
            xa = m_pend[0] & ~mask;
            xb = m_pend[1] & ~mask;
            chk("a.X", x_a, xa);
            chk("a.E", 8'(e_a), 8'(xa == 8'h00));
            chk("a.irq", 8'(irq_a), 8'(xa != 8'h00));
            chk("a.ovr", ovr_a, m_ovr[0]);
            chk("a.ack_err", 8'(aerr_a), 8'(m_aerr[0]));
            chk("b.X", x_b, xb);
            chk("b.E", 8'(e_b), 8'(xb == 8'h00));
            chk("b.irq", 8'(irq_b), 8'(xb != 8'h00));
            chk("b.ovr", ovr_b, m_ovr[1]);
            chk("b.ack_err", 8'(aerr_b), 8'(m_aerr[1]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with all lines high, then one edge each after release
        req_a = 8'hFF;
        step(2);
        chk("t1.rst_X", x_a, 8'h00);
        chk("t1.rst_E", 8'(e_a), 8'h01);
        chk("t1.rst_ovr", ovr_a, 8'h00);
        rst = 1'b0;
        step(3);
        chk("t1.X", x_a, 8'hFF);
        chk("t1.Y", 8'(enc(x_a)), 8'h07);

        req_a = 8'h00; rst = 1'b1; step(2); rst = 1'b0;

        // 2: single pulse on line 2, then ack it
        req_a = 8'h04; step(1); req_a = 8'h00; step(2);
        chk("t2.X", x_a, 8'h04);
        chk("t2.E", 8'(e_a), 8'h00);
        chk("t2.Y", 8'(enc(x_a)), 8'h02);
        ack = 1'b1; ack_idx = 3'd2; step(1); ack = 1'b0;
        chk("t2.X_after_ack", x_a, 8'h00);
        chk("t2.E_after_ack", 8'(e_a), 8'h01);
        chk("t2.irq_after_ack", 8'(irq_a), 8'h00);

        // 3: lines 1 and 6, acked in priority order, then a stray ack
        req_a = 8'h42; step(1); req_a = 8'h00; step(2);
        chk("t3.Y6", 8'(enc(x_a)), 8'h06);
        ack = 1'b1; ack_idx = 3'd6; step(1); ack = 1'b0;
        chk("t3.Y1", 8'(enc(x_a)), 8'h01);
        ack = 1'b1; ack_idx = 3'd1; step(1); ack = 1'b0;
        chk("t3.E", 8'(e_a), 8'h01);
        ack = 1'b1; ack_idx = 3'd1; step(1); ack = 1'b0;
        chk("t3.ack_err_hi", 8'(aerr_a), 8'h01);
        step(1);
        chk("t3.ack_err_lo", 8'(aerr_a), 8'h00);

        // 4: overrun on line 3, clear it, then edge coincident with ack
        req_a = 8'h08; step(1); req_a = 8'h00; step(2);
        req_a = 8'h08; step(1); req_a = 8'h00; step(2);
        chk("t4.ovr_set", ovr_a, 8'h08);
        ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
        chk("t4.ovr_clr", ovr_a, 8'h00);
        req_a = 8'h08; step(1); req_a = 8'h00; step(1);
        ack = 1'b1; ack_idx = 3'd3; step(1); ack = 1'b0;
        chk("t4.keep_X", x_a, 8'h08);
        chk("t4.no_ovr", ovr_a, 8'h00);

        rst = 1'b1; step(1); rst = 1'b0;

        // 5: masking hides line 7 without clearing it
        req_a = 8'h81; step(1); req_a = 8'h00; step(2);
        mask = 8'h80; #1;
        chk("t5.X_masked", x_a, 8'h01);
        chk("t5.Y_masked", 8'(enc(x_a)), 8'h00);
        mask = 8'h00; step(1);
        chk("t5.X_unmasked", x_a, 8'h81);
        chk("t5.Y_unmasked", 8'(enc(x_a)), 8'h07);

        // 6: level line 7 on the second instance
        req_b = 8'h80; step(3);
        chk("t6.X7_held", 8'(x_b[7]), 8'h01);
        ack = 1'b1; ack_idx = 3'd7; step(1); ack = 1'b0;
        chk("t6.X7_after_ack", 8'(x_b[7]), 8'h01);
        chk("t6.no_ack_err", 8'(aerr_b), 8'h00);
        req_b = 8'h00; step(3);
        chk("t6.X7_released", 8'(x_b[7]), 8'h00);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
